seven_seg_scanner: RTL and testbench
====================================

Name: seven_seg_scanner

Overview:
Parametrised multiplexed 7-segment display scanner and the next generation of our single-digit display driver. It scans NUMBER_OF_DIGITS digits, with a per-digit decimal-point mask, hex glyph decode, leading-zero blanking, an anti-ghosting blank interval between digits, and tear-free frame snapshots of the input value. It sits between the stopwatch/timer datapath and the board's common-anode segment/select pins.

Parameters:
NUMBER_OF_DIGITS, 4, digits scanned (1..8)
REFRESH_RATE_IN_HERTZ, 500, full-frame refresh rate
BOARD_CLOCK_FREQUENCY_IN_HZ, 100_000_000, clk frequency
BLANK_CYCLES, 1000, dead-time clocks at the start of each digit slot
Derived: SLOT_CYCLES = BOARD_CLOCK_FREQUENCY_IN_HZ / REFRESH_RATE_IN_HERTZ / NUMBER_OF_DIGITS. Elaboration error unless SLOT_CYCLES > BLANK_CYCLES + 16.

Ports:
clk  in  1  single clock
rst  in  1  synchronous reset, active-high
enable  in  1  scan enable; low = display dark
number  in  4*NUMBER_OF_DIGITS  hex nibbles, digit 0 = bits [3:0] (rightmost)
dp_mask  in  NUMBER_OF_DIGITS  1 = light the DP of that digit
blank_leading_zeros  in  1  1 = suppress leading zero digits
brightness  in  4  PWM duty code (used only with the macro)
io_sel  out  NUMBER_OF_DIGITS  active-low digit selects
io_seg  out  8  active-low segments: [6:0] = gfedcba, [7] = DP
frame_start  out  1  one-clock pulse when a frame begins (snapshot taken)

Behaviour:
- Reset, any cycle: state IDLE, slot_cnt=0, digit=0, shadow registers=0; io_sel all 1, io_seg=8'hFF, frame_start=0.
- States: IDLE, BLANK, DRIVE.
  - IDLE -> BLANK when enable=1. On that transition: digit=0, slot_cnt=0, frame_start=1, and number/dp_mask are loaded into the shadow registers.
  - BLANK -> DRIVE when slot_cnt == BLANK_CYCLES-1.
  - DRIVE -> BLANK when slot_cnt == SLOT_CYCLES-1. slot_cnt resets to 0 and digit increments.
  - When digit wraps from NUMBER_OF_DIGITS-1 to 0: frame_start=1 and the shadow registers reload in the same cycle.
  - Any state -> IDLE on the cycle after enable=0. Counters clear to 0.
- slot_cnt counts 0..SLOT_CYCLES-1 in BLANK and DRIVE, and is held at 0 in IDLE.
- Outputs are registered. io_sel/io_seg reflect the state one clock after it.
  - IDLE/BLANK: io_sel all 1, io_seg=8'hFF.
  - DRIVE: io_sel = ~(1<<digit). io_seg = glyph of shadow nibble[digit], with DP = ~shadow_dp[digit].
- Glyph table (gfedcba, active-low): 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E; blank=7F.
- Leading-zero blanking: digit i>0 shows blank (7F) iff blank_leading_zeros=1 and shadow nibbles N-1..i are all 0. Digit 0 always shows its glyph. DP is unaffected by blanking.
- Inputs are sampled only at a snapshot. Mid-frame changes to number/dp_mask/blank_leading_zeros do not appear until the next frame_start. blank_leading_zeros is snapshotted with number.
- NUMBER_OF_DIGITS=1: every slot is a frame, so frame_start pulses every SLOT_CYCLES.
- rst overrides enable in the same cycle.

Optional Feature:
SEVEN_SEG_BRIGHTNESS_EN
- Defined: in DRIVE, io_sel is asserted only while pwm_cnt <= brightness. pwm_cnt is a 4-bit counter, cleared at DRIVE entry, incrementing each clock. Duty = (brightness+1)/16, so 15 = full-on and 0 = 1/16. io_seg holds the glyph during the off-phase; only io_sel is gated.
- Undefined: the brightness port is ignored, no pwm_cnt exists, and DRIVE is full-on.

Test Plan:
Bench parameters: clock 8000, refresh 100, 4 digits, BLANK_CYCLES 2, giving SLOT_CYCLES 20.
1. rst then enable=1, number=16'h1208, dp_mask=4'b0100 -> frame_start one cycle. Digit 0: io_sel=4'b1110, io_seg=8'h80 for 18 clocks after 2 blank clocks. Digit 2: io_seg=8'h24. Period 80 clocks.
2. number=16'h0047, blank_leading_zeros=1 -> digits 3,2 io_seg=8'hFF. Digit 1 = 8'h99, digit 0 = 8'hF8. number=16'h0000 -> digit 0 = 8'hC0 and the others blank.
3. Change number from 16'h1111 to 16'h2222 during digit 1 DRIVE -> digits 1..3 still show 8'hF9 until the next frame_start, then 8'hA4.
4. Drop enable mid-DRIVE of digit 2 -> next clock IDLE, following clock io_sel=4'hF, io_seg=8'hFF. Re-enable -> restarts at digit 0 with frame_start. Assert rst with enable=1 -> same reset outputs.
5. Number=16'hABCD -> glyphs 21, 46, 03, 08 (+DP off bit) on digits 0..3.
6. With SEVEN_SEG_BRIGHTNESS_EN and brightness=3: in DRIVE, io_sel low 4 of every 16 clocks. With brightness=15: low for all 18 clocks. Without the macro: low for 18 clocks regardless of brightness.

Source files
------------

// File: rtl/seven_seg_scanner_if.sv
// Display-scanner bus: value/control from the datapath, segment and select pins to the board.
`timescale 1ns/1ps

interface seven_seg_scanner_if #(
    parameter int unsigned NUMBER_OF_DIGITS = 4
);
    logic                            enable;
    logic [4*NUMBER_OF_DIGITS-1:0]   number;
    logic [NUMBER_OF_DIGITS-1:0]     dp_mask;
    logic                            blank_leading_zeros;
    logic [3:0]                      brightness;
    logic [NUMBER_OF_DIGITS-1:0]     io_sel;
    logic [7:0]                      io_seg;
    logic                            frame_start;

    // Datapath side: supplies the value, observes the pins.
    modport master (
        output enable, number, dp_mask, blank_leading_zeros, brightness,
        input  io_sel, io_seg, frame_start
    );

    // Scanner side.
    modport slave (
        input  enable, number, dp_mask, blank_leading_zeros, brightness,
        output io_sel, io_seg, frame_start
    );
endinterface

// File: rtl/seven_seg_scanner.sv
// Multiplexed common-anode 7-segment scanner with per-frame snapshots,
// leading-zero blanking and anti-ghosting dead time between digits.
// Optional macro SEVEN_SEG_BRIGHTNESS_EN: PWM-gates the digit selects by brightness.
`timescale 1ns/1ps

module seven_seg_scanner #(
    parameter int unsigned NUMBER_OF_DIGITS            = 4,
    parameter int unsigned REFRESH_RATE_IN_HERTZ       = 500,
    parameter int unsigned BOARD_CLOCK_FREQUENCY_IN_HZ = 100_000_000,
    parameter int unsigned BLANK_CYCLES                = 1000
) (
    input  logic                clk,
    input  logic                rst,
    seven_seg_scanner_if.slave  bus
);

    localparam int unsigned SLOT_CYCLES =
        BOARD_CLOCK_FREQUENCY_IN_HZ / REFRESH_RATE_IN_HERTZ / NUMBER_OF_DIGITS;
    localparam int unsigned SLOT_W  = $clog2(SLOT_CYCLES);
    localparam int unsigned DIGIT_W = (NUMBER_OF_DIGITS > 1) ? $clog2(NUMBER_OF_DIGITS) : 1;
    localparam int unsigned NUM_W   = 4 * NUMBER_OF_DIGITS;

    // Reject configurations that cannot scan sensibly.
    if (NUMBER_OF_DIGITS < 1 || NUMBER_OF_DIGITS > 8) begin : g_bad_digits
        $error("seven_seg_scanner: NUMBER_OF_DIGITS must be 1..8");
    end
    if (SLOT_CYCLES <= BLANK_CYCLES + 16) begin : g_bad_slot
        $error("seven_seg_scanner: SLOT_CYCLES must exceed BLANK_CYCLES + 16");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BLANK = 2'd1,
        ST_DRIVE = 2'd2
    } state_e;

    state_e                      state_q,        state_d;
    logic [SLOT_W-1:0]           slot_cnt_q,     slot_cnt_d;
    logic [DIGIT_W-1:0]          digit_q,        digit_d;
    logic [NUM_W-1:0]            shadow_num_q,   shadow_num_d;
    logic [NUMBER_OF_DIGITS-1:0] shadow_dp_q,    shadow_dp_d;
    logic                        shadow_blz_q,   shadow_blz_d;
    logic [NUMBER_OF_DIGITS-1:0] io_sel_q,       io_sel_d;
    logic [7:0]                  io_seg_q,       io_seg_d;
    logic                        frame_start_q,  frame_start_d;

    logic [3:0]                  nibble_c;
    logic                        upper_zero_c;
    logic                        blank_c;
    logic                        dp_c;
    logic [NUMBER_OF_DIGITS-1:0] sel_c;

`ifdef SEVEN_SEG_BRIGHTNESS_EN
    logic [3:0]                  pwm_cnt_q,      pwm_cnt_d;
`else
    logic                        unused_brightness_c;
    assign unused_brightness_c = ^bus.brightness;
`endif

    // Active-low gfedcba pattern for a hex nibble.
    function automatic logic [6:0] glyph(input logic [3:0] n);
        logic [6:0] g;
        case (n)
            4'h0: g = 7'h40;
            4'h1: g = 7'h79;
            4'h2: g = 7'h24;
            4'h3: g = 7'h30;
            4'h4: g = 7'h19;
            4'h5: g = 7'h12;
            4'h6: g = 7'h02;
            4'h7: g = 7'h78;
            4'h8: g = 7'h00;
            4'h9: g = 7'h10;
            4'hA: g = 7'h08;
            4'hB: g = 7'h03;
            4'hC: g = 7'h46;
            4'hD: g = 7'h21;
            4'hE: g = 7'h06;
            default: g = 7'h0E;
        endcase
        return g;
    endfunction

    // Current digit's nibble, DP, select pattern and leading-zero status from the snapshot.
    always_comb begin
        nibble_c     = 4'(shadow_num_q >> {digit_q, 2'b00});
        upper_zero_c = ((shadow_num_q >> {digit_q, 2'b00}) == '0);
        blank_c      = shadow_blz_q && (digit_q != '0) && upper_zero_c;
        dp_c         = 1'(shadow_dp_q >> digit_q);
        sel_c        = ~(NUMBER_OF_DIGITS'(1) << digit_q);
    end

    // Next-state, counters, snapshot loads and registered pin values.
    always_comb begin
        state_d       = state_q;
        slot_cnt_d    = slot_cnt_q;
        digit_d       = digit_q;
        shadow_num_d  = shadow_num_q;
        shadow_dp_d   = shadow_dp_q;
        shadow_blz_d  = shadow_blz_q;
        frame_start_d = 1'b0;
        io_sel_d      = '1;
        io_seg_d      = 8'hFF;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        pwm_cnt_d     = pwm_cnt_q + 4'd1;
`endif

        unique case (state_q)
            ST_IDLE: begin
                slot_cnt_d = '0;
                digit_d    = '0;
                if (bus.enable) begin
                    state_d       = ST_BLANK;
                    frame_start_d = 1'b1;
                    shadow_num_d  = bus.number;
                    shadow_dp_d   = bus.dp_mask;
                    shadow_blz_d  = bus.blank_leading_zeros;
                end
            end
            ST_BLANK: begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                if (slot_cnt_q == SLOT_W'(BLANK_CYCLES - 1)) begin
                    state_d = ST_DRIVE;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
                    pwm_cnt_d = '0;
`endif
                end
            end
            ST_DRIVE: begin
                slot_cnt_d = slot_cnt_q + SLOT_W'(1);
                io_sel_d   = sel_c;
                io_seg_d   = {~dp_c, blank_c ? 7'h7F : glyph(nibble_c)};
`ifdef SEVEN_SEG_BRIGHTNESS_EN
                if (pwm_cnt_q > bus.brightness) begin
                    io_sel_d = '1;
                end
`endif
                if (slot_cnt_q == SLOT_W'(SLOT_CYCLES - 1)) begin
                    slot_cnt_d = '0;
                    state_d    = ST_BLANK;
                    if (digit_q == DIGIT_W'(NUMBER_OF_DIGITS - 1)) begin
                        digit_d       = '0;
                        frame_start_d = 1'b1;
                        shadow_num_d  = bus.number;
                        shadow_dp_d   = bus.dp_mask;
                        shadow_blz_d  = bus.blank_leading_zeros;
                    end else begin
                        digit_d = digit_q + DIGIT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Dropping enable darkens the display and restarts from digit 0 later.
        if (!bus.enable && (state_q != ST_IDLE)) begin
            state_d       = ST_IDLE;
            slot_cnt_d    = '0;
            digit_d       = '0;
            frame_start_d = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            slot_cnt_q    <= '0;
            digit_q       <= '0;
            shadow_num_q  <= '0;
            shadow_dp_q   <= '0;
            shadow_blz_q  <= 1'b0;
            io_sel_q      <= '1;
            io_seg_q      <= 8'hFF;
            frame_start_q <= 1'b0;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
            pwm_cnt_q     <= '0;
`endif
        end else begin
            state_q       <= state_d;
            slot_cnt_q    <= slot_cnt_d;
            digit_q       <= digit_d;
            shadow_num_q  <= shadow_num_d;
            shadow_dp_q   <= shadow_dp_d;
            shadow_blz_q  <= shadow_blz_d;
            io_sel_q      <= io_sel_d;
            io_seg_q      <= io_seg_d;
            frame_start_q <= frame_start_d;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
            pwm_cnt_q     <= pwm_cnt_d;
`endif
        end
    end

    assign bus.io_sel      = io_sel_q;
    assign bus.io_seg      = io_seg_q;
    assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner: 4 digits, 20-clock slots with 2 dead-time clocks.
// Expected digit windows go into a queue; a monitor pops one per observed window.
`timescale 1ns/1ps

module tb_seven_seg_scanner;

    localparam int unsigned N = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    seven_seg_scanner_if #(.NUMBER_OF_DIGITS(N)) bus ();

    seven_seg_scanner #(
        .NUMBER_OF_DIGITS            (N),
        .REFRESH_RATE_IN_HERTZ       (100),
        .BOARD_CLOCK_FREQUENCY_IN_HZ (8000),
        .BLANK_CYCLES                (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    bit          mon_en = 1'b0;
    logic [11:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Pops one expected {sel,seg} at the start of each lit-digit window and checks its length.
    task automatic monitor_loop();
        logic [3:0]  prev   = 4'hF;
        bit          in_win = 1'b0;
        int          run_len = 0;
        logic [11:0] e;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                in_win = 1'b0;
            end else if (bus.io_sel != 4'hF) begin
                if (prev == 4'hF) begin
                    checks++;
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL window_unexpected actual sel=%h seg=%h required no window",
                                 bus.io_sel, bus.io_seg);
                    end else begin
                        e = exp_q.pop_front();
                        if ({bus.io_sel, bus.io_seg} !== e) begin
                            errors++;
                            $display("FAIL window actual sel=%h seg=%h required sel=%h seg=%h",
                                     bus.io_sel, bus.io_seg, e[11:8], e[7:0]);
                        end
                    end
                    in_win  = 1'b1;
                    run_len = 1;
                end else if (in_win) begin
                    run_len++;
                end
            end else if (prev != 4'hF && in_win) begin
                chk("window_len", run_len, 18);
                in_win = 1'b0;
            end
            prev = bus.io_sel;
        end
    endtask

    task automatic wait_fs(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (bus.frame_start === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL frame_start_timeout actual=none required=pulse within 200 clocks");
        end
    endtask

    // Expect one whole frame of four digit windows; optionally change number mid-frame.
    task automatic check_frame(input string name,
                               input logic [11:0] e0, input logic [11:0] e1,
                               input logic [11:0] e2, input logic [11:0] e3,
                               input bit mid, input logic [15:0] mid_num);
        bit ok;
        wait_fs(ok);
        if (!ok) return;
        exp_q.push_back(e0);
        exp_q.push_back(e1);
        exp_q.push_back(e2);
        exp_q.push_back(e3);
        mon_en = 1'b1;
        if (mid) begin
            repeat (30) @(negedge clk);
            bus.number = mid_num;
        end
        wait_fs(ok);
        repeat (2) @(negedge clk);
        mon_en = 1'b0;
        chk({name, "_drained"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic count_low(input string name, input int req);
        bit ok;
        int lows;
        lows = 0;
        wait_fs(ok);
        repeat (2) @(negedge clk);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.io_sel[0] == 1'b0) lows++;
        end
        chk(name, lows, req);
    endtask

    initial begin
        bit ok;
        int n;

        bus.enable              = 1'b0;
        bus.number              = 16'h1208;
        bus.dp_mask             = 4'b0100;
        bus.blank_leading_zeros = 1'b0;
        bus.brightness          = 4'hF;

        fork
            monitor_loop();
        join_none

        // Reset state, and reset winning over enable.
        repeat (3) @(negedge clk);
        chk("reset_sel", bus.io_sel, 4'hF);
        chk("reset_seg", bus.io_seg, 8'hFF);
        chk("reset_fs",  bus.frame_start, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("reset_en_sel", bus.io_sel, 4'hF);
        chk("reset_en_fs",  bus.frame_start, 0);
        rst = 1'b0;

        // Basic frame with DP on digit 2.
        check_frame("t1", {4'hE, 8'h80}, {4'hD, 8'hC0}, {4'hB, 8'h24}, {4'h7, 8'hF9}, 1'b0, 16'h0);

        // Frame period.
        wait_fs(ok);
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (bus.frame_start === 1'b1) break;
        end
        chk("frame_period", n, 80);

        // Leading-zero blanking.
        bus.number              = 16'h0047;
        bus.dp_mask             = 4'b0000;
        bus.blank_leading_zeros = 1'b1;
        check_frame("t2a", {4'hE, 8'hF8}, {4'hD, 8'h99}, {4'hB, 8'hFF}, {4'h7, 8'hFF}, 1'b0, 16'h0);
        bus.number = 16'h0000;
        check_frame("t2b", {4'hE, 8'hC0}, {4'hD, 8'hFF}, {4'hB, 8'hFF}, {4'h7, 8'hFF}, 1'b0, 16'h0);
        bus.blank_leading_zeros = 1'b0;

        // Mid-frame change is held off until the next snapshot.
        bus.number = 16'h1111;
        check_frame("t3a", {4'hE, 8'hF9}, {4'hD, 8'hF9}, {4'hB, 8'hF9}, {4'h7, 8'hF9}, 1'b1, 16'h2222);
        check_frame("t3b", {4'hE, 8'hA4}, {4'hD, 8'hA4}, {4'hB, 8'hA4}, {4'h7, 8'hA4}, 1'b0, 16'h0);

        // Letter glyphs.
        bus.number = 16'hABCD;
        check_frame("t5", {4'hE, 8'hA1}, {4'hD, 8'hC6}, {4'hB, 8'h83}, {4'h7, 8'h88}, 1'b0, 16'h0);

        // Brightness gating of the selects.
        bus.brightness = 4'd3;
`ifdef SEVEN_SEG_BRIGHTNESS_EN
        count_low("pwm_b3_low", 6);
`else
        count_low("pwm_b3_low", 18);
`endif
        bus.brightness = 4'd15;
        count_low("pwm_b15_low", 18);

        // Drop enable during digit 2 drive, then re-enable.
        wait_fs(ok);
        repeat (48) @(negedge clk);
        chk("pre_drop_sel", bus.io_sel, 4'hB);
        bus.enable = 1'b0;
        @(negedge clk);
        chk("drop_lag_sel", bus.io_sel, 4'hB);
        @(negedge clk);
        chk("drop_sel", bus.io_sel, 4'hF);
        chk("drop_seg", bus.io_seg, 8'hFF);
        repeat (3) @(negedge clk);
        chk("idle_sel", bus.io_sel, 4'hF);
        chk("idle_fs",  bus.frame_start, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        chk("reenable_fs", bus.frame_start, 1);
        repeat (3) @(negedge clk);
        chk("restart_sel", bus.io_sel, 4'hE);
        chk("restart_seg", bus.io_seg, 8'hA1);

        // Reset while enabled.
        rst = 1'b1;
        @(negedge clk);
        chk("rst_en_sel", bus.io_sel, 4'hF);
        chk("rst_en_seg", bus.io_seg, 8'hFF);
        chk("rst_en_fs",  bus.frame_start, 0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_fs", bus.frame_start, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
